// File: rtl/fp_hazard_scoreboard.sv
// fp_hazard_scoreboard: RAW/WAW stall, ID/EXE forwarding and a countdown
// scoreboard for long-latency FP results; saturating stall-cycle counter.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   src_*_id / src_*_exe    per-source address, FP-file flag, valid
//   rd_mem, rd_wb, we_*     MEM/WB destination and int/FP write enables
//   issue_valid/rd/fp/lat   instruction leaving ID and its result latency
//   stall_id                hold ID (RAW on busy entry or WAW)
//   fwd_id                  per-source take WB result in ID
//   fwd_exe                 per-source 00 regfile, 01 MEM, 10 WB
//   stall_cnt               saturating count of stalled cycles
module fp_hazard_scoreboard #(
  parameter int NUM_SRC = 3,
  parameter int LAT_W   = 5,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5*NUM_SRC-1:0] src_addr_id,
  input  logic [NUM_SRC-1:0]   src_fp_id,
  input  logic [NUM_SRC-1:0]   src_valid_id,
  input  logic [5*NUM_SRC-1:0] src_addr_exe,
  input  logic [NUM_SRC-1:0]   src_fp_exe,
  input  logic [NUM_SRC-1:0]   src_valid_exe,
  input  logic [4:0]           rd_mem,
  input  logic [4:0]           rd_wb,
  input  logic                 we_int_mem,
  input  logic                 we_fp_mem,
  input  logic                 we_int_wb,
  input  logic                 we_fp_wb,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_fp,
  input  logic [LAT_W-1:0]     issue_lat,
  output logic                 stall_id,
  output logic [NUM_SRC-1:0]   fwd_id,
  output logic [2*NUM_SRC-1:0] fwd_exe,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int NENT = 64;

  // Entry index is {fp, addr}; {0, x0} is only ever reset, so it reads 0.
  logic [LAT_W-1:0] cnt [NENT];

  logic [NUM_SRC-1:0] raw_hit;
  logic               waw_hit;
  logic [5:0]         iss_idx;
  logic               issue_eff;
  logic [NUM_SRC-1:0] mem_hit;
  logic [NUM_SRC-1:0] wb_hit;

  // Busy means cnt > 1: any bit above bit 0 set.
  function automatic logic busy(logic [LAT_W-1:0] c);
    return |c[LAT_W-1:1];
  endfunction

  // A write hits a source when the file matches and the address matches;
  // integer writes to x0 never hit, f0 is a real register.
  function automatic logic wr_hit(
    logic       fp,
    logic [4:0] a,
    logic       we_i,
    logic       we_f,
    logic [4:0] rd
  );
    return (a == rd) && (fp ? we_f : (we_i && (rd != 5'd0)));
  endfunction

  assign iss_idx = {issue_fp, issue_rd};

  always_comb begin
    raw_hit = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      raw_hit[k] = src_valid_id[k] &&
        busy(cnt[{src_fp_id[k], src_addr_id[5*k +: 5]}]);
    end
  end

  assign waw_hit  = issue_valid && busy(cnt[iss_idx]);
  assign stall_id = (|raw_hit) || waw_hit;

  assign issue_eff = issue_valid && !stall_id &&
                     (issue_lat != '0) &&
                     !(!issue_fp && (issue_rd == 5'd0));

  always_comb begin
    fwd_id  = '0;
    mem_hit = '0;
    wb_hit  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_id[k] = src_valid_id[k] &&
        wr_hit(src_fp_id[k], src_addr_id[5*k +: 5],
               we_int_wb, we_fp_wb, rd_wb);
      mem_hit[k] = src_valid_exe[k] &&
        wr_hit(src_fp_exe[k], src_addr_exe[5*k +: 5],
               we_int_mem, we_fp_mem, rd_mem);
      wb_hit[k] = src_valid_exe[k] &&
        wr_hit(src_fp_exe[k], src_addr_exe[5*k +: 5],
               we_int_wb, we_fp_wb, rd_wb);
    end
  end

  // MEM is younger than WB, so it wins when both match.
  always_comb begin
    fwd_exe = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      unique case (1'b1)
        mem_hit[k]:               fwd_exe[2*k +: 2] = 2'b01;
        wb_hit[k] && !mem_hit[k]: fwd_exe[2*k +: 2] = 2'b10;
        default:                  fwd_exe[2*k +: 2] = 2'b00;
      endcase
    end
  end

  // Countdown runs regardless of stall: the FP units are decoupled
  // from the pipeline. A new issue reloads its entry over the decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NENT; i++) begin
        if (issue_eff && (iss_idx == 6'(i))) begin
          cnt[i] <= issue_lat;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_id && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_hazard_scoreboard.sv
// tb_fp_hazard_scoreboard: directed scenarios plus random traffic
// checked against a ready-time model of the FP scoreboard.
module tb_fp_hazard_scoreboard;

  localparam int NS   = 3;
  localparam int LW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5*NS-1:0] src_addr_id;
  logic [NS-1:0]   src_fp_id;
  logic [NS-1:0]   src_valid_id;
  logic [5*NS-1:0] src_addr_exe;
  logic [NS-1:0]   src_fp_exe;
  logic [NS-1:0]   src_valid_exe;
  logic [4:0]      rd_mem;
  logic [4:0]      rd_wb;
  logic            we_int_mem;
  logic            we_fp_mem;
  logic            we_int_wb;
  logic            we_fp_wb;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_fp;
  logic [LW-1:0]   issue_lat;
  logic            stall_id;
  logic [NS-1:0]   fwd_id;
  logic [2*NS-1:0] fwd_exe;
  logic [CW-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  fp_hazard_scoreboard #(
    .NUM_SRC(NS),
    .LAT_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_addr_id  (src_addr_id),
    .src_fp_id    (src_fp_id),
    .src_valid_id (src_valid_id),
    .src_addr_exe (src_addr_exe),
    .src_fp_exe   (src_fp_exe),
    .src_valid_exe(src_valid_exe),
    .rd_mem       (rd_mem),
    .rd_wb        (rd_wb),
    .we_int_mem   (we_int_mem),
    .we_fp_mem    (we_fp_mem),
    .we_int_wb    (we_int_wb),
    .we_fp_wb     (we_fp_wb),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_fp     (issue_fp),
    .issue_lat    (issue_lat),
    .stall_id     (stall_id),
    .fwd_id       (fwd_id),
    .fwd_exe      (fwd_exe),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: a register is busy until the cycle its result is one
  // cycle from WB, stored as an absolute cycle number.
  int unsigned cyc;
  int unsigned free_at [64];
  int unsigned m_scnt;

  function automatic bit m_busy(int idx);
    return cyc < free_at[idx];
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (src_valid_id[k] &&
          m_busy({src_fp_id[k], src_addr_id[5*k +: 5]})) s = 1'b1;
    end
    if (issue_valid && m_busy({issue_fp, issue_rd})) s = 1'b1;
    return s;
  endfunction

  function automatic bit writes(bit fp, logic [4:0] a, bit wi,
                                bit wf, logic [4:0] rd);
    if (a != rd) return 1'b0;
    if (fp) return wf;
    return wi && rd != 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) free_at[i] <= 0;
      m_scnt <= 0;
    end else begin
      if (m_stall() && m_scnt < CMAX) m_scnt <= m_scnt + 1;
      cyc <= cyc + 1;
      if (!m_stall() && issue_valid && issue_lat != 0 &&
          !(!issue_fp && issue_rd == 0))
        free_at[{issue_fp, issue_rd}] <= cyc + issue_lat;
    end
  end

  task automatic clear_inputs();
    src_addr_id   = '0;
    src_fp_id     = '0;
    src_valid_id  = '0;
    src_addr_exe  = '0;
    src_fp_exe    = '0;
    src_valid_exe = '0;
    rd_mem        = '0;
    rd_wb         = '0;
    we_int_mem    = 1'b0;
    we_fp_mem     = 1'b0;
    we_int_wb     = 1'b0;
    we_fp_wb      = 1'b0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    issue_fp      = 1'b0;
    issue_lat     = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    src_valid_id  = 3'b111;
    src_valid_exe = 3'b111;
    reset = 1'b1;
    #3;
    checks++;
    if (stall_id !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", stall_id);
    end
    checks++;
    if (fwd_id !== 3'b000) begin
      errors++; $display("FAIL reset_fwd_id got %b want 000", fwd_id);
    end
    checks++;
    if (fwd_exe !== 6'b0) begin
      errors++; $display("FAIL reset_fwd_exe got %b want 0", fwd_exe);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_raw();
    do_reset();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_fp = 1'b1; issue_lat = 5'd4;
    @(posedge clk); #1;
    clear_inputs();
    src_valid_id = 3'b011;
    src_fp_id    = 3'b011;
    src_addr_id  = {5'd0, 5'd5, 5'd5};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stall_id !== 1'b1) begin
        errors++; $display("FAIL raw_stall c%0d got %b want 1", i, stall_id);
      end
      @(posedge clk); #1;
    end
    we_fp_wb = 1'b1; rd_wb = 5'd5;
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b0) begin
      errors++; $display("FAIL raw_release got %b want 0", stall_id);
    end
    checks++;
    if (fwd_id !== 3'b011) begin
      errors++; $display("FAIL raw_fwd_id got %b want 011", fwd_id);
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL raw_cnt got %0d want 3", stall_cnt);
    end
    we_int_wb = 1'b1; we_fp_wb = 1'b0; rd_wb = 5'd0;
    src_valid_id = 3'b011; src_fp_id = 3'b010;
    src_addr_id = {5'd0, 5'd0, 5'd0};
    #1;
    checks++;
    if (fwd_id !== 3'b000) begin
      errors++; $display("FAIL fwd_id_x0 got %b want 000", fwd_id);
    end
    we_int_wb = 1'b0; we_fp_wb = 1'b1;
    #1;
    checks++;
    if (fwd_id !== 3'b010) begin
      errors++; $display("FAIL fwd_id_f0 got %b want 010", fwd_id);
    end
    clear_inputs();
  endtask

  task automatic test_file_isolation();
    clear_inputs();
    we_int_mem = 1'b1; rd_mem = 5'd3;
    src_valid_exe = 3'b001; src_addr_exe = {10'd0, 5'd3}; src_fp_exe = 3'b001;
    #1;
    checks++;
    if (fwd_exe[1:0] !== 2'b00) begin
      errors++; $display("FAIL iso_fp got %b want 00", fwd_exe[1:0]);
    end
    src_fp_exe = 3'b000;
    #1;
    checks++;
    if (fwd_exe[1:0] !== 2'b01) begin
      errors++; $display("FAIL iso_int got %b want 01", fwd_exe[1:0]);
    end
    rd_mem = 5'd0; src_addr_exe = '0;
    #1;
    checks++;
    if (fwd_exe[1:0] !== 2'b00) begin
      errors++; $display("FAIL iso_x0 got %b want 00", fwd_exe[1:0]);
    end
    we_int_mem = 1'b0; we_fp_mem = 1'b1; src_fp_exe = 3'b001;
    #1;
    checks++;
    if (fwd_exe[1:0] !== 2'b01) begin
      errors++; $display("FAIL iso_f0 got %b want 01", fwd_exe[1:0]);
    end
    clear_inputs();
  endtask

  task automatic test_mem_priority();
    clear_inputs();
    we_int_mem = 1'b1; we_int_wb = 1'b1; rd_mem = 5'd7; rd_wb = 5'd7;
    src_valid_exe = 3'b010; src_addr_exe = {5'd0, 5'd7, 5'd0};
    #1;
    checks++;
    if (fwd_exe !== 6'b000100) begin
      errors++; $display("FAIL prio_mem got %b want 000100", fwd_exe);
    end
    we_int_mem = 1'b0;
    #1;
    checks++;
    if (fwd_exe !== 6'b001000) begin
      errors++; $display("FAIL prio_wb got %b want 001000", fwd_exe);
    end
    src_valid_exe = 3'b000;
    #1;
    checks++;
    if (fwd_exe !== 6'b000000) begin
      errors++; $display("FAIL prio_invalid got %b want 0", fwd_exe);
    end
    clear_inputs();
  endtask

  task automatic test_waw_reload();
    do_reset();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_fp = 1'b1; issue_lat = 5'd3;
    @(posedge clk); #1;
    issue_lat = 5'd5;
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b1) begin
      errors++; $display("FAIL waw_stall got %b want 1", stall_id);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    src_valid_id = 3'b001; src_fp_id = 3'b001; src_addr_id = {10'd0, 5'd9};
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b1) begin
      errors++; $display("FAIL waw_hold got %b want 1", stall_id);
    end
    @(posedge clk); #1;
    issue_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b0) begin
      errors++; $display("FAIL waw_unchanged got %b want 0", stall_id);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (stall_id !== 1'b1) begin
        errors++; $display("FAIL reload_busy c%0d got %b want 1", i, stall_id);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b0) begin
      errors++; $display("FAIL reload_done got %b want 0", stall_id);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd2; issue_fp = 1'b1; issue_lat = 5'd20;
    @(posedge clk); #1;
    clear_inputs();
    src_valid_id = 3'b100; src_fp_id = 3'b100; src_addr_id = {5'd2, 10'd0};
    @(negedge clk);
    checks++;
    if (stall_id !== 1'b1) begin
      errors++; $display("FAIL mid_busy got %b want 1", stall_id);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stall_id !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got %b/%0d want 0/0", stall_id, stall_cnt);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    clear_inputs();
    issue_valid = 1'b1; issue_rd = 5'd1; issue_fp = 1'b1; issue_lat = 5'd31;
    @(posedge clk); #1;
    clear_inputs();
    src_valid_id = 3'b001; src_fp_id = 3'b001; src_addr_id = {10'd0, 5'd1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 14) begin
        checks++;
        if (stall_cnt !== 4'd14) begin
          errors++; $display("FAIL sat_pre got %0d want 14", stall_cnt);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_cnt got %0d want 15", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NS-1:0]   e_fid;
    logic [2*NS-1:0] e_fex;
    bit              e_st;
    bit              mh;
    bit              wh;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NS; k++) begin
        src_addr_id[5*k +: 5]  = 5'($urandom_range(0, 3));
        src_addr_exe[5*k +: 5] = 5'($urandom_range(0, 3));
      end
      src_fp_id     = 3'($urandom);
      src_valid_id  = 3'($urandom);
      src_fp_exe    = 3'($urandom);
      src_valid_exe = 3'($urandom);
      rd_mem        = 5'($urandom_range(0, 3));
      rd_wb         = 5'($urandom_range(0, 3));
      we_int_mem    = 1'($urandom);
      we_fp_mem     = 1'($urandom);
      we_int_wb     = 1'($urandom);
      we_fp_wb      = 1'($urandom);
      issue_valid   = 1'($urandom);
      issue_rd      = 5'($urandom_range(0, 3));
      issue_fp      = 1'($urandom);
      issue_lat     = 5'($urandom_range(0, 6));
      if (c % 100 == 50) reset = 1'b1;
      @(negedge clk);
      e_st = m_stall();
      e_fid = '0;
      e_fex = '0;
      for (int k = 0; k < NS; k++) begin
        e_fid[k] = src_valid_id[k] &&
          writes(src_fp_id[k], src_addr_id[5*k +: 5],
                 we_int_wb, we_fp_wb, rd_wb);
        mh = writes(src_fp_exe[k], src_addr_exe[5*k +: 5],
                    we_int_mem, we_fp_mem, rd_mem);
        wh = writes(src_fp_exe[k], src_addr_exe[5*k +: 5],
                    we_int_wb, we_fp_wb, rd_wb);
        if (!src_valid_exe[k]) e_fex[2*k +: 2] = 2'b00;
        else if (mh)           e_fex[2*k +: 2] = 2'b01;
        else if (wh)           e_fex[2*k +: 2] = 2'b10;
      end
      checks++;
      if (stall_id !== e_st) begin
        errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall_id, e_st);
      end
      checks++;
      if (fwd_id !== e_fid) begin
        errors++; $display("FAIL rnd_fwd_id c%0d got %b want %b", c, fwd_id, e_fid);
      end
      checks++;
      if (fwd_exe !== e_fex) begin
        errors++; $display("FAIL rnd_fwd_exe c%0d got %b want %b", c, fwd_exe, e_fex);
      end
      checks++;
      if (32'(stall_cnt) !== m_scnt) begin
        errors++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, stall_cnt, m_scnt);
      end
      reset = 1'b0;
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    cyc = 0;
    clear_inputs();
    test_reset();
    test_raw();
    test_file_isolation();
    test_mem_priority();
    test_waw_reload();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
